demux1x4_buf: RTL and testbench

- Registered 1-to-4 demultiplexer with valid/ready handshake.
- Inverse of the datapath 4:1 select muxes: routes one 48-bit source word to one of four consumers, chosen by a 2-bit select.
- Each output has a one-entry holding buffer, so a stalled consumer does not block words routed to the other outputs.
- Sits between the fetch/operand source and per-unit consumers in the processor datapath.

---
 rtl/demux1x4_buf_pkg.sv | 33 +++
 rtl/demux1x4_buf_if.sv | 47 ++++
 rtl/demux1x4_buf_slot.sv | 68 ++++++
 rtl/demux1x4_buf.sv | 88 ++++++++
 tb/tb_demux1x4_buf.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/demux1x4_buf_pkg.sv
// demux1x4_buf_pkg: shared constants and helpers for the 1-to-4 buffered demux.
//   DEFAULT_DATA_W / DEFAULT_CNT_W : default word and statistics-counter widths
//   SEL_W, NUM_OUT                 : select width and number of destinations
//   OUT_0..OUT_3                   : named destination indices
//   sel_onehot()                   : select index to one-hot destination mask
package demux1x4_buf_pkg;

  localparam int DEFAULT_DATA_W = 48;
  localparam int DEFAULT_CNT_W  = 16;
  localparam int SEL_W          = 2;
  localparam int NUM_OUT        = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t OUT_0 = 2'd0;
  localparam sel_t OUT_1 = 2'd1;
  localparam sel_t OUT_2 = 2'd2;
  localparam sel_t OUT_3 = 2'd3;

  // Decode a destination index into a one-hot slot mask.
  function automatic logic [NUM_OUT-1:0] sel_onehot(input sel_t sel);
    logic [NUM_OUT-1:0] mask;
    case (sel)
      OUT_0:   mask = 4'b0001;
      OUT_1:   mask = 4'b0010;
      OUT_2:   mask = 4'b0100;
      OUT_3:   mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/demux1x4_buf_if.sv
// demux1x4_buf_if: source-side and consumer-side handshake bundle.
//   in_data/in_select/in_valid -> source word, destination, presence
//   in_ready                   <- word accepted when in_valid is also high
//   outN_data/outN_valid       <- buffered word per destination
//   outN_ready                 -> consumer N takes the word
// Modports: master = source plus consumers, slave = the demux.
interface demux1x4_buf_if
  import demux1x4_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [0:DATA_W-1] in_data;
  sel_t              in_select;
  logic              in_valid;
  logic              in_ready;

  logic [0:DATA_W-1] out0_data;
  logic [0:DATA_W-1] out1_data;
  logic [0:DATA_W-1] out2_data;
  logic [0:DATA_W-1] out3_data;
  logic              out0_valid;
  logic              out1_valid;
  logic              out2_valid;
  logic              out3_valid;
  logic              out0_ready;
  logic              out1_ready;
  logic              out2_ready;
  logic              out3_ready;

  modport master (
    output in_data, in_select, in_valid,
    input  in_ready,
    input  out0_data, out1_data, out2_data, out3_data,
    input  out0_valid, out1_valid, out2_valid, out3_valid,
    output out0_ready, out1_ready, out2_ready, out3_ready
  );

  modport slave (
    input  in_data, in_select, in_valid,
    output in_ready,
    output out0_data, out1_data, out2_data, out3_data,
    output out0_valid, out1_valid, out2_valid, out3_valid,
    input  out0_ready, out1_ready, out2_ready, out3_ready
  );

endinterface

// File: rtl/demux1x4_buf_slot.sv
// demux_slot: one-entry holding buffer for a single demux destination.
//   clk, reset  : clock, synchronous active-high reset
//   load        : store load_data this cycle
//   load_data   : word to store
//   ready       : consumer takes the held word
//   full, data  : registered buffer state (full doubles as the valid flag)
//   cnt         : drain counter, saturating (only with DEMUX1X4_STATS_EN)
module demux_slot
  import demux1x4_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [0:DATA_W-1] load_data,
  input  logic              ready,
  output logic              full,
  output logic [0:DATA_W-1] data
`ifdef DEMUX1X4_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  logic              full_r;
  logic [0:DATA_W-1] data_r;
  logic              drain_s;

  assign drain_s = full_r & ready;

  // Buffer state: a load wins over a same-cycle drain, so the slot stays full
  // and sustains one word per cycle; data only moves on a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else begin
      full_r <= load | (full_r & ~ready);
      if (load) begin
        data_r <= load_data;
      end
    end
  end

  assign full = full_r;
  assign data = data_r;

`ifdef DEMUX1X4_STATS_EN
  logic [CNT_W-1:0] cnt_r;

  // Drain counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (drain_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign cnt = cnt_r;
`else
  logic unused_drain_s;
  assign unused_drain_s = drain_s;
`endif

endmodule

// File: rtl/demux1x4_buf.sv
// demux1x4_buf: registered 1-to-4 demultiplexer with a one-entry buffer per
// destination, so a stalled consumer never blocks the other three.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : source handshake in_*, consumer handshakes outN_*
//   cnt0..cnt3   : per-destination drain counters, present only when the
//                  macro DEMUX1X4_STATS_EN is defined
// in_ready is combinational on in_select and the selected slot only; it does
// not look at in_valid.
module demux1x4_buf
  import demux1x4_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  demux1x4_buf_if.slave    bus
`ifdef DEMUX1X4_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  logic [NUM_OUT-1:0] full_s;
  logic [NUM_OUT-1:0] ready_s;
  logic [NUM_OUT-1:0] load_s;
  logic [0:DATA_W-1]  data_s [NUM_OUT];
  logic               in_ready_s;
  logic               accept_s;

  assign ready_s = {bus.out3_ready, bus.out2_ready, bus.out1_ready, bus.out0_ready};

  // Selected slot can take a word if it is empty or being drained this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (bus.in_select)
      OUT_0:   in_ready_s = ~full_s[0] | ready_s[0];
      OUT_1:   in_ready_s = ~full_s[1] | ready_s[1];
      OUT_2:   in_ready_s = ~full_s[2] | ready_s[2];
      OUT_3:   in_ready_s = ~full_s[3] | ready_s[3];
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s     = bus.in_valid & in_ready_s;
  assign load_s       = sel_onehot(bus.in_select) & {NUM_OUT{accept_s}};
  assign bus.in_ready = in_ready_s;

`ifdef DEMUX1X4_STATS_EN
  logic [CNT_W-1:0] cnt_s [NUM_OUT];
  assign cnt0 = cnt_s[0];
  assign cnt1 = cnt_s[1];
  assign cnt2 = cnt_s[2];
  assign cnt3 = cnt_s[3];
`endif

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s[g]),
      .load_data (bus.in_data),
      .ready     (ready_s[g]),
      .full      (full_s[g]),
      .data      (data_s[g])
`ifdef DEMUX1X4_STATS_EN
      ,
      .cnt       (cnt_s[g])
`endif
    );
  end

  assign bus.out0_valid = full_s[0];
  assign bus.out1_valid = full_s[1];
  assign bus.out2_valid = full_s[2];
  assign bus.out3_valid = full_s[3];
  assign bus.out0_data  = data_s[0];
  assign bus.out1_data  = data_s[1];
  assign bus.out2_data  = data_s[2];
  assign bus.out3_data  = data_s[3];

endmodule

// File: tb/tb_demux1x4_buf.sv
// tb_demux1x4_buf: directed bench for demux1x4_buf. The driver pushes each
// word it expects to be accepted into a per-destination queue; a monitor on
// the falling edge pops and compares whenever a consumer takes a word.
module tb_demux1x4_buf;
  import demux1x4_buf_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [47:0] q0[$];
  logic [47:0] q1[$];
  logic [47:0] q2[$];
  logic [47:0] q3[$];

  demux1x4_buf_if #(.DATA_W(48)) bus ();

`ifdef DEMUX1X4_STATS_EN
  logic [1:0] cnt0, cnt1, cnt2, cnt3;
  demux1x4_buf #(.DATA_W(48), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );
`else
  demux1x4_buf #(.DATA_W(48)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one cycle, check in_ready, record the expected delivery.
  task automatic send(input logic [1:0] sel, input logic [47:0] d, input logic exp_rdy);
    bus.in_select = sel;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    #3;
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    if (exp_rdy) begin
      case (sel)
        2'd0:    q0.push_back(d);
        2'd1:    q1.push_back(d);
        2'd2:    q2.push_back(d);
        default: q3.push_back(d);
      endcase
    end
    tick();
  endtask

  task automatic check_all_empty(input string name);
    check({name, "_valids"},
          {60'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid, bus.out0_valid}, 64'd0);
    check({name, "_d0"}, {16'd0, bus.out0_data}, 64'd0);
    check({name, "_d1"}, {16'd0, bus.out1_data}, 64'd0);
    check({name, "_d2"}, {16'd0, bus.out2_data}, 64'd0);
    check({name, "_d3"}, {16'd0, bus.out3_data}, 64'd0);
  endtask

  // Scoreboard monitor: every consumer transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out0_valid && bus.out0_ready) begin
        if (q0.size() == 0) check("q0_underflow", 64'd1, 64'd0);
        else check("out0_data", {16'd0, bus.out0_data}, {16'd0, q0.pop_front()});
      end
      if (bus.out1_valid && bus.out1_ready) begin
        if (q1.size() == 0) check("q1_underflow", 64'd1, 64'd0);
        else check("out1_data", {16'd0, bus.out1_data}, {16'd0, q1.pop_front()});
      end
      if (bus.out2_valid && bus.out2_ready) begin
        if (q2.size() == 0) check("q2_underflow", 64'd1, 64'd0);
        else check("out2_data", {16'd0, bus.out2_data}, {16'd0, q2.pop_front()});
      end
      if (bus.out3_valid && bus.out3_ready) begin
        if (q3.size() == 0) check("q3_underflow", 64'd1, 64'd0);
        else check("out3_data", {16'd0, bus.out3_data}, {16'd0, q3.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.in_data   = 48'h0;
    bus.in_select = 2'd0;
    bus.in_valid  = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    bus.out3_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_all_empty("reset");

    // Single word to out2, one-cycle latency, other outputs untouched.
    send(2'd2, 48'h555555555555, 1'b1);
    bus.in_valid = 1'b0;
    check("t1_out2_valid", {63'd0, bus.out2_valid}, 64'd1);
    check("t1_out2_data", {16'd0, bus.out2_data}, 64'h0000555555555555);
    check("t1_other_valids", {61'd0, bus.out3_valid, bus.out1_valid, bus.out0_valid}, 64'd0);
    bus.out2_ready = 1'b1;
    tick();
    bus.out2_ready = 1'b0;
    check("t1_out2_drained", {63'd0, bus.out2_valid}, 64'd0);

    // Stall on full out0, then release with simultaneous drain and load.
    send(2'd0, 48'hffffffffffff, 1'b1);
    send(2'd0, 48'h000000000000, 1'b0);
    check("t2_hold_data", {16'd0, bus.out0_data}, 64'h0000ffffffffffff);
    check("t2_hold_valid", {63'd0, bus.out0_valid}, 64'd1);
    bus.out0_ready = 1'b1;
    send(2'd0, 48'h000000000000, 1'b1);
    bus.in_valid = 1'b0;
    check("t2_replaced_data", {16'd0, bus.out0_data}, 64'd0);
    check("t2_replaced_valid", {63'd0, bus.out0_valid}, 64'd1);
    tick();
    bus.out0_ready = 1'b0;

    // Stalled out1 does not block a word for out3.
    send(2'd1, 48'h111122223333, 1'b1);
    send(2'd1, 48'h444455556666, 1'b0);
    send(2'd3, 48'haaaaaaaaaaaa, 1'b1);
    bus.in_valid = 1'b0;
    check("t3_out1_data", {16'd0, bus.out1_data}, 64'h0000111122223333);
    check("t3_out1_valid", {63'd0, bus.out1_valid}, 64'd1);
    check("t3_out3_data", {16'd0, bus.out3_data}, 64'h0000aaaaaaaaaaaa);
    check("t3_out3_valid", {63'd0, bus.out3_valid}, 64'd1);
    bus.out1_ready = 1'b1;
    bus.out3_ready = 1'b1;
    tick();
    bus.out1_ready = 1'b0;
    bus.out3_ready = 1'b0;

    // Back-to-back stream into out2 with the consumer always ready.
    bus.out2_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(2'd2, 48'(i), 1'b1);
      check("t4_out2_valid", {63'd0, bus.out2_valid}, 64'd1);
      check("t4_out2_data", {16'd0, bus.out2_data}, 64'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out2_ready = 1'b0;
    check("t4_out2_empty", {63'd0, bus.out2_valid}, 64'd0);

    // Reset while every slot is full and a word is being accepted.
    send(2'd0, 48'h0a0a0a0a0a0a, 1'b1);
    send(2'd1, 48'h0b0b0b0b0b0b, 1'b1);
    send(2'd2, 48'h0c0c0c0c0c0c, 1'b1);
    send(2'd3, 48'h0d0d0d0d0d0d, 1'b1);
    bus.in_valid = 1'b0;
    check("t5_all_full", {60'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid, bus.out0_valid}, 64'hf);
    bus.in_select  = 2'd0;
    bus.in_data    = 48'hdeadbeefcafe;
    bus.in_valid   = 1'b1;
    bus.out0_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    check_all_empty("t5_reset");
    tick();
    check("t5_nothing_captured",
          {60'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid, bus.out0_valid}, 64'd0);

    // Five drains of out0; with statistics, the counter saturates at 3.
    bus.out0_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      send(2'd0, 48'h000000000100 + 48'(k), 1'b1);
`ifdef DEMUX1X4_STATS_EN
      check("t6_cnt0", {62'd0, cnt0}, (k - 1 > 3) ? 64'd3 : 64'(k - 1));
`endif
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out0_ready = 1'b0;
`ifdef DEMUX1X4_STATS_EN
    check("t6_cnt0_final", {62'd0, cnt0}, 64'd3);
    check("t6_cnt_others", {58'd0, cnt3, cnt2, cnt1}, 64'd0);
`endif
    check("t6_out0_empty", {63'd0, bus.out0_valid}, 64'd0);

    check("scoreboard_left", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
